// File: rtl/jtkcpu_shseq_pkg.sv
// Shared opcode constants, sequencer state encoding and D-shift decode helpers.
// Also used by the control unit to recognise multi-bit D shifts.
package jtkcpu_shseq_pkg;

    localparam logic [7:0] LSRD_IMM = 8'h63;
    localparam logic [7:0] LSRD_IDX = 8'h64;
    localparam logic [7:0] RORD_IMM = 8'h65;
    localparam logic [7:0] RORD_IDX = 8'h66;
    localparam logic [7:0] ASRD_IMM = 8'h67;
    localparam logic [7:0] ASRD_IDX = 8'h68;
    localparam logic [7:0] ASLD_IMM = 8'h69;
    localparam logic [7:0] ASLD_IDX = 8'h6A;
    localparam logic [7:0] ROLD_IMM = 8'h6B;
    localparam logic [7:0] ROLD_IDX = 8'h6C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } shseq_state_t;

    function automatic logic is_dshift(input logic [7:0] op);
        case (op)
            LSRD_IMM, LSRD_IDX, RORD_IMM, RORD_IDX, ASRD_IMM,
            ASRD_IDX, ASLD_IMM, ASLD_IDX, ROLD_IMM, ROLD_IDX: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Plain shifts saturate after 17 steps; rotates through C have period 17 and do not.
    function automatic logic is_clampable(input logic [7:0] op);
        case (op)
            LSRD_IMM, LSRD_IDX, ASRD_IMM, ASRD_IDX, ASLD_IMM, ASLD_IDX: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtkcpu_shseq.sv
// Multi-bit D shift sequencer: iterates the single-step ALU once per shift count.
// Optional macro JTKCPU_SHSEQ_CLAMP_EN clamps non-rotate shift counts to 17.
module jtkcpu_shseq
    import jtkcpu_shseq_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          start,
    input  logic [7:0]    op,
    input  logic [15:0]   opnd0,
    input  logic [CW-1:0] cnt,
    input  logic [7:0]    cc_in,
    output logic [7:0]    alu_op,
    output logic [15:0]   alu_opnd0,
    output logic [7:0]    alu_cc,
    input  logic [15:0]   alu_rslt,
    input  logic [7:0]    alu_cc_out,
    input  logic          alu_busy,
    output logic          busy,
    output logic          done,
    output logic [15:0]   rslt,
    output logic [7:0]    cc_out,
    output logic [1:0]    st_dbg
);

    // Handshake: start is taken only in IDLE on a cen cycle; busy stays high
    // through ITER and DONE, done marks the single cycle where rslt/cc_out are fresh.

    shseq_state_t  state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [15:0]   acc_q, acc_d;
    logic [7:0]    acc_cc_q, acc_cc_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   rslt_q, rslt_d;
    logic [7:0]    cc_out_q, cc_out_d;
    logic [CW-1:0] load_cnt;

    always_comb begin
        load_cnt = cnt;
`ifdef JTKCPU_SHSEQ_CLAMP_EN
        if (is_clampable(op) && (32'(cnt) > 32'd17)) begin
            load_cnt = CW'(17);
        end
`else
        if (is_clampable(op) && 1'b0) begin
            load_cnt = cnt;
        end
`endif
        if (!is_dshift(op)) begin
            load_cnt = CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        acc_cc_d = acc_cc_q;
        count_d  = count_q;
        rslt_d   = rslt_q;
        cc_out_d = cc_out_q;
        if (cen) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d     = op;
                        acc_d    = opnd0;
                        acc_cc_d = cc_in;
                        count_d  = load_cnt;
                        if (load_cnt == '0) begin
                            rslt_d   = opnd0;
                            cc_out_d = cc_in;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (!alu_busy) begin
                        acc_d    = alu_rslt;
                        acc_cc_d = alu_cc_out;
                        count_d  = count_q - CW'(1);
                        if (count_q == CW'(1)) begin
                            rslt_d   = alu_rslt;
                            cc_out_d = alu_cc_out;
                            state_d  = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            acc_cc_q <= '0;
            count_q  <= '0;
            rslt_q   <= '0;
            cc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            acc_cc_q <= acc_cc_d;
            count_q  <= count_d;
            rslt_q   <= rslt_d;
            cc_out_q <= cc_out_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_opnd0 = acc_q;
    assign alu_cc    = acc_cc_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rslt      = rslt_q;
    assign cc_out    = cc_out_q;
    assign st_dbg    = state_q;

endmodule

// File: tb/tb_jtkcpu_shseq.sv
// Bench for jtkcpu_shseq with a behavioural single-step D-shift ALU.
// Expected latencies follow JTKCPU_SHSEQ_CLAMP_EN when it is defined.
module tb_jtkcpu_shseq;
    import jtkcpu_shseq_pkg::*;

    logic        rst, clk, cen, start;
    logic [7:0]  op;
    logic [15:0] opnd0;
    logic [7:0]  cnt;
    logic [7:0]  cc_in;
    logic [7:0]  alu_op;
    logic [15:0] alu_opnd0;
    logic [7:0]  alu_cc;
    logic [15:0] alu_rslt;
    logic [7:0]  alu_cc_out;
    logic        alu_busy;
    logic        busy, done;
    logic [15:0] rslt;
    logic [7:0]  cc_out;
    logic [1:0]  st_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    jtkcpu_shseq #(.CW(8)) dut (
        .rst(rst), .clk(clk), .cen(cen), .start(start), .op(op), .opnd0(opnd0),
        .cnt(cnt), .cc_in(cc_in), .alu_op(alu_op), .alu_opnd0(alu_opnd0),
        .alu_cc(alu_cc), .alu_rslt(alu_rslt), .alu_cc_out(alu_cc_out),
        .alu_busy(alu_busy), .busy(busy), .done(done), .rslt(rslt),
        .cc_out(cc_out), .st_dbg(st_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-step ALU model; CC bits: N=3 Z=2 V=1 C=0
    always_comb begin
        alu_rslt   = alu_opnd0 + 16'd1;
        alu_cc_out = alu_cc;
        case (alu_op)
            LSRD_IMM, LSRD_IDX: begin
                alu_rslt = {1'b0, alu_opnd0[15:1]};
                alu_cc_out[0] = alu_opnd0[0];
            end
            ASRD_IMM, ASRD_IDX: begin
                alu_rslt = {alu_opnd0[15], alu_opnd0[15:1]};
                alu_cc_out[0] = alu_opnd0[0];
            end
            RORD_IMM, RORD_IDX: begin
                alu_rslt = {alu_cc[0], alu_opnd0[15:1]};
                alu_cc_out[0] = alu_opnd0[0];
            end
            ASLD_IMM, ASLD_IDX: begin
                alu_rslt = {alu_opnd0[14:0], 1'b0};
                alu_cc_out[0] = alu_opnd0[15];
                alu_cc_out[1] = alu_opnd0[15] ^ alu_opnd0[14];
            end
            ROLD_IMM, ROLD_IDX: begin
                alu_rslt = {alu_opnd0[14:0], alu_cc[0]};
                alu_cc_out[0] = alu_opnd0[15];
                alu_cc_out[1] = alu_opnd0[15] ^ alu_opnd0[14];
            end
            default: ;
        endcase
        if (is_dshift(alu_op)) begin
            alu_cc_out[3] = alu_rslt[15];
            alu_cc_out[2] = (alu_rslt == 16'd0);
        end
    end

    typedef struct {
        logic [7:0]  op;
        logic [15:0] d;
        logic [7:0]  cnt;
        logic [7:0]  cc;
        logic [15:0] e_rslt;
        logic [7:0]  e_cc;
        int          e_lat;
    } vec_t;

`ifdef JTKCPU_SHSEQ_CLAMP_EN
    localparam int LAT_200 = 18;
    localparam int LAT_20  = 18;
    localparam int LAT_255 = 18;
`else
    localparam int LAT_200 = 201;
    localparam int LAT_20  = 21;
    localparam int LAT_255 = 256;
`endif

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive one transaction; cen_tog/stall/restart perturb cen, alu_busy and start while busy
    task automatic run_vec(input vec_t v, input bit cen_tog, input bit stall,
                           input bit restart, input string tag);
        int edges;
        int prod;
        logic [23:0] e;
        op = v.op; opnd0 = v.d; cnt = v.cnt; cc_in = v.cc;
        cen = 1'b1; alu_busy = 1'b0; start = 1'b1;
        exp_q.push_back({v.e_rslt, v.e_cc});
        @(posedge clk); #1;
        start = 1'b0; op = 8'h00; opnd0 = 16'hDEAD; cnt = 8'h00; cc_in = 8'hFF;
        edges = 1; prod = 1;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        if (v.e_lat > 1) check({tag, " alu_op latched"}, 32'(alu_op), 32'(v.op));
        while (!done && edges < 1000) begin
            cen      = cen_tog ? (edges % 2 == 0) : 1'b1;
            alu_busy = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            start    = restart ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            if (cen && !alu_busy) prod++;
            #1;
            edges++;
        end
        start = 1'b0; alu_busy = 1'b0;
        check({tag, " done seen"}, 32'(done), 32'd1);
        e = exp_q.pop_front();
        check({tag, " rslt"}, 32'(rslt), 32'(e[23:8]));
        check({tag, " cc_out"}, 32'(cc_out), 32'(e[7:0]));
        check({tag, " latency"}, 32'(prod), 32'(v.e_lat));
        if (cen_tog) begin
            cen = 1'b0;
            @(posedge clk); #1;
            check({tag, " done held cen=0"}, 32'(done), 32'd1);
        end
        cen = 1'b1;
        @(posedge clk); #1;
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle after done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " rslt held"}, 32'(rslt), 32'(e[23:8]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{LSRD_IMM, 16'h8001, 8'd1,   8'h00, 16'h4000, 8'h01, 2};
        vecs[1]  = '{ASLD_IDX, 16'h0001, 8'd15,  8'h00, 16'h8000, 8'h0A, 16};
        vecs[2]  = '{ASLD_IDX, 16'h0001, 8'd16,  8'h00, 16'h0000, 8'h07, 17};
        vecs[3]  = '{RORD_IMM, 16'h1234, 8'd17,  8'h50, 16'h1234, 8'h50, 18};
        vecs[4]  = '{LSRD_IDX, 16'h1357, 8'd0,   8'hA5, 16'h1357, 8'hA5, 1};
        vecs[5]  = '{ASRD_IMM, 16'h8000, 8'd200, 8'h00, 16'hFFFF, 8'h09, LAT_200};
        vecs[6]  = '{ROLD_IMM, 16'h8001, 8'd1,   8'h00, 16'h0002, 8'h03, 2};
        vecs[7]  = '{8'h01,    16'h00FF, 8'd0,   8'h3C, 16'h0100, 8'h3C, 2};
        vecs[8]  = '{LSRD_IDX, 16'hFFFF, 8'd20,  8'h0F, 16'h0000, 8'h06, LAT_20};
        vecs[9]  = '{ASLD_IMM, 16'h00FF, 8'd255, 8'h00, 16'h0000, 8'h04, LAT_255};
        vecs[10] = '{ROLD_IDX, 16'h8000, 8'd34,  8'h00, 16'h8000, 8'h0A, 35};

        // reset with start held high: reset wins
        rst = 1'b1; cen = 1'b1; start = 1'b1; alu_busy = 1'b0;
        op = ASRD_IMM; opnd0 = 16'h5555; cnt = 8'd3; cc_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rslt", 32'(rslt), 32'd0);
        check("reset cc_out", 32'(cc_out), 32'd0);
        check("reset alu_op", 32'(alu_op), 32'd0);
        check("reset alu_opnd0", 32'(alu_opnd0), 32'd0);
        check("reset alu_cc", 32'(alu_cc), 32'd0);
        check("reset state", 32'(st_dbg), 32'(S_IDLE));
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        run_vec(vecs[5], 1'b1, 1'b0, 1'b0, "cen_toggle");
        run_vec(vecs[10], 1'b0, 1'b1, 1'b1, "stall_restart");
        run_vec(vecs[2], 1'b1, 1'b1, 1'b1, "all_perturb");

        // reset mid-ITER with cen low: aborts with no done pulse
        op = ASRD_IMM; opnd0 = 16'h8000; cnt = 8'd200; cc_in = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid busy before rst", 32'(busy), 32'd1);
        check("mid state ITER", 32'(st_dbg), 32'(S_ITER));
        rst = 1'b1; cen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; cen = 1'b1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst rslt", 32'(rslt), 32'd0);
        check("mid rst alu_op", 32'(alu_op), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("no done after rst", 32'({busy, done}), 32'd0);
        end

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
